sipo_rx: RTL and testbench

//  Serial-in/parallel-out receiver; the receiving end of our PISO serial link.

---
 rtl/sipo_rx_pkg.sv | 14 +
 rtl/sipo_rx_shift_reg.sv | 38 +++
 rtl/sipo_rx.sv | 118 +++++++++++
 tb/tb_sipo_rx.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/sipo_rx_pkg.sv
// Shared link definitions for the PISO/SIPO pair.
// Both link ends import this so width, bit order and FSM encoding agree.
package sipo_rx_pkg;

  localparam int LINK_WIDTH      = 4;
  localparam bit ORDER_MSB_FIRST = 1'b1;
  localparam bit ORDER_LSB_FIRST = 1'b0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } sipo_state_e;

endpackage

// File: rtl/sipo_rx_shift_reg.sv
// Shift core of the SIPO receiver.
// Exposes the next-state word so a completing bit is captured the same edge.
module sipo_shift_reg
  import sipo_rx_pkg::*;
#(
  parameter int WIDTH     = LINK_WIDTH,
  parameter bit MSB_FIRST = ORDER_MSB_FIRST
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             d_in,
  output logic [WIDTH-1:0] q_d
);

  logic [WIDTH-1:0] sh_q;

  generate
    if (MSB_FIRST) begin : g_msb
      assign q_d = {sh_q[WIDTH-2:0], d_in};
    end else begin : g_lsb
      assign q_d = {d_in, sh_q[WIDTH-1:1]};
    end
  endgenerate

  // Shift register: cleared by reset or abort, advances on qualified bits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_q <= '0;
    end else if (clr) begin
      sh_q <= '0;
    end else if (en) begin
      sh_q <= q_d;
    end
  end

endmodule

// File: rtl/sipo_rx.sv
// Serial-in/parallel-out receiver with valid/ready output and overrun flag.
// Counter, FSM, output word register and handshake live here.
module sipo_rx
  import sipo_rx_pkg::*;
#(
  parameter int WIDTH     = LINK_WIDTH,
  parameter bit MSB_FIRST = ORDER_MSB_FIRST
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             d_in,
  input  logic             d_valid,
  output logic [WIDTH-1:0] p_out,
  output logic             p_valid,
  input  logic             p_ready,
  output logic             busy,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sipo_state_e      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] p_out_q, p_out_d;
  logic             p_valid_q, p_valid_d;
  logic             overrun_q, overrun_d;
  logic             sh_en, sh_clr, done;
  logic [WIDTH-1:0] sh_nxt;

  sipo_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk   (clk),
    .rst_n (reset),
    .clr   (sh_clr),
    .en    (sh_en),
    .d_in  (d_in),
    .q_d   (sh_nxt)
  );

  // Next state: abort first, then bit collection and output handshake
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    p_out_d   = p_out_q;
    p_valid_d = p_valid_q;
    overrun_d = overrun_q;
    sh_en     = 1'b0;
    sh_clr    = 1'b0;
    done      = 1'b0;
    if (clear) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      sh_clr    = 1'b1;
      overrun_d = 1'b0;
    end else begin
      if (p_valid_q && p_ready) begin
        p_valid_d = 1'b0;
      end
      if (d_valid) begin
        sh_en = 1'b1;
        unique case (state_q)
          ST_IDLE: begin
            cnt_d   = CW'(1);
            state_d = ST_SHIFT;
          end
          ST_SHIFT: begin
            if (cnt_q == LAST) begin
              done    = 1'b1;
              cnt_d   = '0;
              state_d = ST_IDLE;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        endcase
      end
      if (done) begin
        if (!p_valid_q || p_ready) begin
          p_out_d   = sh_nxt;
          p_valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      p_out_q   <= '0;
      p_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      p_out_q   <= p_out_d;
      p_valid_q <= p_valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign p_out   = p_out_q;
  assign p_valid = p_valid_q;
  assign busy    = (state_q == ST_SHIFT);
  assign overrun = overrun_q;

endmodule

// File: tb/tb_sipo_rx.sv
// Randomized and directed bench for sipo_rx.
// Two instances (MSB-first and LSB-first) share stimulus and a word model.
module tb_sipo_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b0;
  logic       clear = 1'b0;
  logic       d_in = 1'b0;
  logic       d_valid = 1'b0;
  logic       p_ready = 1'b0;
  logic [3:0] po_m, po_l;
  logic       pv_m, pv_l, b_m, b_l, ov_m, ov_l;

  sipo_rx #(.WIDTH(4), .MSB_FIRST(1)) u_msb (
    .clk(clk), .reset(reset), .clear(clear),
    .d_in(d_in), .d_valid(d_valid),
    .p_out(po_m), .p_valid(pv_m), .p_ready(p_ready),
    .busy(b_m), .overrun(ov_m)
  );

  sipo_rx #(.WIDTH(4), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .reset(reset), .clear(clear),
    .d_in(d_in), .d_valid(d_valid),
    .p_out(po_l), .p_valid(pv_l), .p_ready(p_ready),
    .busy(b_l), .overrun(ov_l)
  );

  int checks = 0;
  int errors = 0;

  // Model: bits received so far in arrival order
  bit       m_bits[4];
  int       m_n = 0;
  bit [3:0] m_po[2];
  bit       m_pv[2];
  bit       m_ov[2];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit [3:0] mk_word(bit msb);
    bit [3:0] w;
    for (int i = 0; i < 4; i++) begin
      if (msb) w[3 - i] = m_bits[i];
      else     w[i]     = m_bits[i];
    end
    return w;
  endfunction

  task automatic model_edge();
    bit full;
    bit [3:0] w;
    full = 1'b0;
    if (!reset) begin
      m_n = 0;
      for (int k = 0; k < 2; k++) begin
        m_po[k] = '0; m_pv[k] = 0; m_ov[k] = 0;
      end
    end else if (clear) begin
      m_n = 0;
      m_ov[0] = 0;
      m_ov[1] = 0;
    end else begin
      if (d_valid) begin
        m_bits[m_n] = d_in;
        m_n++;
        if (m_n == 4) begin
          full = 1'b1;
          m_n = 0;
        end
      end
      for (int k = 0; k < 2; k++) begin
        w = mk_word(k == 0);
        if (full && (!m_pv[k] || p_ready)) begin
          m_po[k] = w;
          m_pv[k] = 1;
        end else if (full) begin
          m_ov[k] = 1;
        end else if (m_pv[k] && p_ready) begin
          m_pv[k] = 0;
        end
      end
    end
  endtask

  task automatic compare();
    chk("msb_p_out",   po_m, m_po[0]);
    chk("msb_p_valid", pv_m, m_pv[0]);
    chk("msb_busy",    b_m,  m_n != 0);
    chk("msb_overrun", ov_m, m_ov[0]);
    chk("lsb_p_out",   po_l, m_po[1]);
    chk("lsb_p_valid", pv_l, m_pv[1]);
    chk("lsb_busy",    b_l,  m_n != 0);
    chk("lsb_overrun", ov_l, m_ov[1]);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic send(bit b);
    d_valid = 1'b1;
    d_in    = b;
    step();
  endtask

  task automatic idle();
    d_valid = 1'b0;
    step();
  endtask

  initial begin
    // Reset for two edges
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    idle();
    chk("rst_p_out", po_m, 4'h0);
    chk("rst_busy", b_m, 1'b0);
    chk("rst_p_valid", pv_m, 1'b0);

    // Basic word 1001
    send(1);
    chk("basic_busy", b_m, 1'b1);
    send(0); send(0); send(1);
    chk("basic_pv", pv_m, 1'b1);
    chk("basic_po", po_m, 4'b1001);
    d_valid = 1'b0;
    p_ready = 1'b1;
    step();
    p_ready = 1'b0;
    chk("basic_taken", pv_m, 1'b0);

    // Gapped 1010 then back-to-back 1111, consumer always ready
    p_ready = 1'b1;
    send(1); idle(); send(0); idle(); idle();
    send(1); idle(); send(0);
    chk("gap_po", po_m, 4'b1010);
    send(1); send(1); send(1); send(1);
    chk("b2b_po", po_m, 4'b1111);
    chk("b2b_ov", ov_m, 1'b0);
    idle();
    p_ready = 1'b0;

    // Overrun
    send(1); send(0); send(0); send(1);
    send(0); send(1); send(1); send(0);
    idle();
    chk("ovr_po", po_m, 4'b1001);
    chk("ovr_flag", ov_m, 1'b1);
    clear = 1'b1;
    idle();
    clear = 1'b0;
    chk("clr_ov", ov_m, 1'b0);
    chk("clr_pv", pv_m, 1'b1);

    // Abort mid-word with clear, then a full word
    p_ready = 1'b1;
    idle();
    p_ready = 1'b0;
    send(1); send(1);
    clear = 1'b1;
    send(1);
    clear = 1'b0;
    chk("abort_busy", b_m, 1'b0);
    send(0); send(1); send(1); send(0);
    chk("abort_po", po_m, 4'b0110);

    // Reset mid-word with a pending word
    send(1); send(0);
    reset = 1'b0;
    idle();
    reset = 1'b1;
    chk("mrst_po", po_m, 4'h0);
    chk("mrst_pv", pv_m, 1'b0);
    chk("mrst_busy", b_m, 1'b0);

    // LSB-first order and completion with valid and ready together
    send(1); send(0); send(0); send(0);
    chk("lsb_po", po_l, 4'b0001);
    chk("lsb_msb_po", po_m, 4'b1000);
    send(1); send(1); send(0);
    p_ready = 1'b1;
    send(0);
    p_ready = 1'b0;
    chk("lsb_swap_po", po_l, 4'b0011);
    chk("lsb_swap_pv", pv_l, 1'b1);
    chk("lsb_swap_ov", ov_l, 1'b0);
    idle();

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      reset   = ($urandom_range(0, 299) != 0);
      clear   = ($urandom_range(0, 59) == 0);
      d_valid = ($urandom_range(0, 9) < 7);
      d_in    = $urandom_range(0, 1);
      p_ready = ($urandom_range(0, 9) < 3);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
